// File: rtl/ps2_msg_pkg.sv
// Shared state encoding and ASCII constants for the PS/2 message builder.
package ps2_msg_pkg;

  typedef enum logic [1:0] {
    EDIT  = 2'd0,
    SEND  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [7:0] ASCII_BS         = 8'h08;
  localparam logic [7:0] ASCII_CR         = 8'h0D;
  localparam logic [7:0] ASCII_PRINT_LO   = 8'h20;
  localparam logic [7:0] ASCII_PRINT_HI   = 8'h7E;
  localparam logic [7:0] PAD_CHAR_DEFAULT = 8'h20;

endpackage

// File: rtl/ps2_message_builder_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level into the clock domain.
module sync_2ff (
  input  logic clock,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ps2_message_builder.sv
// Builds a typed message from ASCII key events and hands it to the GPIO link,
// holding it stable until the link's write-done handshake completes.
module ps2_message_builder
  import ps2_msg_pkg::*;
#(
  parameter int         MSG_CHARS = 16,
  parameter logic [7:0] PAD_CHAR  = PAD_CHAR_DEFAULT
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   key_valid,
  input  logic [7:0]             key_ascii,
  input  logic                   send_done,
  output logic [MSG_CHARS*8-1:0] message_out,
  output logic                   msg_ready,
  output logic [4:0]             char_count,
  output logic                   overflow
);

  localparam logic [4:0] FULL_COUNT = 5'(MSG_CHARS);

  state_t state;
  logic   key_prev;
  logic   done_sync;
  logic   key_event;
  logic   is_print;

  sync_2ff u_done_sync (
    .clock  (clock),
    .resetn (resetn),
    .d      (send_done),
    .q      (done_sync)
  );

  assign key_event = key_valid && !key_prev;
  assign is_print  = (key_ascii >= ASCII_PRINT_LO) && (key_ascii <= ASCII_PRINT_HI);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= EDIT;
      message_out <= {MSG_CHARS{PAD_CHAR}};
      char_count  <= '0;
      msg_ready   <= 1'b0;
      overflow    <= 1'b0;
      key_prev    <= 1'b0;
    end else begin
      key_prev <= key_valid;
      unique case (state)
        EDIT: begin
          if (key_event) begin
            if (is_print) begin
              if (char_count < FULL_COUNT) begin
                message_out[8*32'(char_count) +: 8] <= key_ascii;
                char_count <= char_count + 5'd1;
              end else begin
                overflow <= 1'b1;
              end
            end else if (key_ascii == ASCII_BS) begin
              if (char_count != '0) begin
                message_out[8*32'(char_count - 5'd1) +: 8] <= PAD_CHAR;
                char_count <= char_count - 5'd1;
              end
            end else if (key_ascii == ASCII_CR) begin
              if (char_count != '0) begin
                msg_ready <= 1'b1;
                state     <= SEND;
              end
            end
          end
        end
        SEND: begin
          if (done_sync) begin
            msg_ready <= 1'b0;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          // Wait for the link to release write-done before reopening the buffer.
          if (!done_sync) begin
            message_out <= {MSG_CHARS{PAD_CHAR}};
            char_count  <= '0;
            overflow    <= 1'b0;
            state       <= EDIT;
          end
        end
        default: state <= EDIT;
      endcase
    end
  end

endmodule
